// File: rtl/fb_clock_checker_pkg.sv
// ----------------------------------------------------------------------------
// fb_clock_checker_pkg : state encoding and width helper for the checker. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fb_clock_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_EVAL = 2'd3
   } state_t;

   // Bits needed to hold values 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fb_clock_checker_sync_rise_det.sv
// ----------------------------------------------------------------------------
// fb_clock_checker_sync_rise_det : synchronizer chain plus rising-edge detect. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fb_clock_checker_sync_rise_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic I,
   output logic O_RISE
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], I};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Combinational so the edge is counted on the very next clock.
   assign O_RISE = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/fb_clock_checker.sv
// ----------------------------------------------------------------------------
// fb_clock_checker : counts looped-back clock edges per gate window, reports status. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fb_clock_checker
   import fb_clock_checker_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 1000000,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned MIN_CNT     = 0,
   parameter int unsigned MAX_CNT     = 2**24-1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PASS_NEEDED = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             I_EN,
   input  logic             I_SIG,
   output logic [CNT_W-1:0] O_CNT,
   output logic             O_VALID,
   output logic             O_INRANGE,
   output logic             O_LOSS,
   output logic             O_GOOD
);

   localparam int unsigned            C_GATE_W      = clog2(GATE_CYCLES);
   localparam int unsigned            C_STREAK_W    = clog2(PASS_NEEDED + 1);
   localparam logic [C_GATE_W-1:0]    C_GATE_LOAD   = C_GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]       C_CNT_MAX     = '1;
   localparam logic [C_STREAK_W-1:0]  C_STREAK_FULL = C_STREAK_W'(PASS_NEEDED);
   localparam bit                     C_MAX_IS_FULL =
      (64'(MAX_CNT) >= ((64'd1 << CNT_W) - 64'd1));

   state_t                  r_state;
   state_t                  w_state_nx;
   logic [C_GATE_W-1:0]     r_gate;
   logic [CNT_W-1:0]        r_edge_cnt;
   logic [C_STREAK_W-1:0]   r_streak;
   logic [C_STREAK_W-1:0]   w_streak_nx;
   logic                    w_rise;
   logic                    w_arm;
   logic                    w_meas;
   logic                    w_eval;
   logic                    w_abort;
   logic                    w_ge_min;
   logic                    w_le_max;
   logic                    w_inrange;

   fb_clock_checker_sync_rise_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .I      (I_SIG),
      .O_RISE (w_rise)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_arm      = 1'b0;
      w_meas     = 1'b0;
      w_eval     = 1'b0;
      w_abort    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (I_EN) begin
               w_state_nx = ST_ARM;
            end
         end
         ST_ARM: begin
            if (!I_EN) begin
               w_abort    = 1'b1;
               w_state_nx = ST_IDLE;
            end else begin
               w_arm      = 1'b1;
               w_state_nx = ST_MEAS;
            end
         end
         ST_MEAS: begin
            if (!I_EN) begin
               w_abort    = 1'b1;
               w_state_nx = ST_IDLE;
            end else begin
               w_meas = 1'b1;
               if (r_gate == '0) begin
                  w_state_nx = ST_EVAL;
               end
            end
         end
         ST_EVAL: begin
            // Disable here still lets the finished window publish.
            w_eval     = 1'b1;
            w_state_nx = I_EN ? ST_ARM : ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Bounds that cover the whole count range need no comparator.
   generate
      if (MIN_CNT == 0) begin : g_min_open
         assign w_ge_min = 1'b1;
      end else begin : g_min_cmp
         localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_CNT);
         assign w_ge_min = (r_edge_cnt >= C_MIN);
      end

      if (C_MAX_IS_FULL) begin : g_max_open
         assign w_le_max = 1'b1;
      end else begin : g_max_cmp
         localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CNT);
         assign w_le_max = (r_edge_cnt <= C_MAX);
      end
   endgenerate

   assign w_inrange = w_ge_min & w_le_max;

   always_comb begin
      w_streak_nx = '0;
      if (w_inrange) begin
         w_streak_nx = (r_streak == C_STREAK_FULL) ? r_streak : r_streak + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_gate     <= '0;
         r_edge_cnt <= '0;
         r_streak   <= '0;
         O_CNT      <= '0;
         O_VALID    <= 1'b0;
         O_INRANGE  <= 1'b0;
         O_LOSS     <= 1'b0;
         O_GOOD     <= 1'b0;
      end else begin
         O_VALID <= 1'b0;
         if (w_arm) begin
            r_edge_cnt <= '0;
            r_gate     <= C_GATE_LOAD;
         end
         if (w_meas) begin
            if (w_rise && (r_edge_cnt != C_CNT_MAX)) begin
               r_edge_cnt <= r_edge_cnt + 1'b1;
            end
            // Wraps on the last cycle; ARM reloads before next use.
            r_gate <= r_gate - 1'b1;
         end
         if (w_abort) begin
            r_streak <= '0;
            O_GOOD   <= 1'b0;
         end
         if (w_eval) begin
            O_CNT     <= r_edge_cnt;
            O_VALID   <= 1'b1;
            O_INRANGE <= w_inrange;
            O_LOSS    <= (r_edge_cnt == '0);
            r_streak  <= w_streak_nx;
            O_GOOD    <= (w_streak_nx == C_STREAK_FULL);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fb_clock_checker.sv
// ----------------------------------------------------------------------------
// tb_fb_clock_checker : randomized bench with window-level reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fb_clock_checker;

   localparam int     G    = 100;
   localparam int     MINC = 18;
   localparam int     MAXC = 22;
   localparam int     PN   = 3;
   localparam int     CW   = 24;
   localparam longint CMAX = (longint'(1) << CW) - 1;
   localparam int     RSZ  = 16384;

   logic clk     = 1'b0;
   logic rstn    = 1'b0;
   logic en      = 1'b0;
   logic sig     = 1'b0;
   logic sig_sat = 1'b0;

   logic [CW-1:0] cnt;
   logic          valid, inr, loss, good;
   logic [4:0]    cnt31, cnt30;
   logic          v31, i31, l31, g31, v30, i30, l30, g30;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Stimulus generator state
   int   per = 5, hi = 2, ph = 0;
   bit   noise = 0;
   logic cur_good = 1'b0, last_good = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fb_clock_checker #(
      .GATE_CYCLES (G), .CNT_W (CW), .MIN_CNT (MINC), .MAX_CNT (MAXC),
      .SYNC_STAGES (2), .PASS_NEEDED (PN)
   ) u_dut (
      .CLK (clk), .RSTN (rstn), .I_EN (en), .I_SIG (sig),
      .O_CNT (cnt), .O_VALID (valid), .O_INRANGE (inr), .O_LOSS (loss), .O_GOOD (good)
   );

   fb_clock_checker #(
      .GATE_CYCLES (G), .CNT_W (5), .MIN_CNT (0), .MAX_CNT (31),
      .SYNC_STAGES (2), .PASS_NEEDED (PN)
   ) u_sat31 (
      .CLK (clk), .RSTN (rstn), .I_EN (1'b1), .I_SIG (sig_sat),
      .O_CNT (cnt31), .O_VALID (v31), .O_INRANGE (i31), .O_LOSS (l31), .O_GOOD (g31)
   );

   fb_clock_checker #(
      .GATE_CYCLES (G), .CNT_W (5), .MIN_CNT (0), .MAX_CNT (30),
      .SYNC_STAGES (2), .PASS_NEEDED (PN)
   ) u_sat30 (
      .CLK (clk), .RSTN (rstn), .I_EN (1'b1), .I_SIG (sig_sat),
      .O_CNT (cnt30), .O_VALID (v30), .O_INRANGE (i30), .O_LOSS (l30), .O_GOOD (g30)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // A window armed in cycle a counts synchronized rises seen in cycles a+1..a+G
   // and publishes in cycle a+G+2; a rise seen in cycle c means the pin was
   // sampled low at edge c-2 and high at edge c-1.
   bit     rise_at [RSZ];
   int     m_arm;
   bit     m_x1, m_x2;
   int     m_streak;
   longint e_cnt;
   bit     e_valid, e_inr, e_loss, e_good;

   task automatic model_reset();
      m_arm = -1; m_x1 = 0; m_x2 = 0; m_streak = 0;
      e_cnt = 0; e_valid = 0; e_inr = 0; e_loss = 0; e_good = 0;
   endtask

   task automatic model_publish();
      longint sum;
      sum = 0;
      for (int i = m_arm + 1; i <= m_arm + G; i++) sum += longint'(rise_at[i % RSZ]);
      e_cnt    = (sum > CMAX) ? CMAX : sum;
      e_inr    = (e_cnt >= MINC) && (e_cnt <= MAXC);
      e_loss   = (e_cnt == 0);
      m_streak = e_inr ? ((m_streak < PN) ? m_streak + 1 : PN) : 0;
      e_good   = (m_streak == PN);
      e_valid  = 1;
   endtask

   // Predicts outputs for cycle c given the inputs sampled at edge c.
   task automatic model_step(input int c, input bit en_s, input bit sig_s);
      rise_at[c % RSZ] = m_x1 & ~m_x2;
      m_x2 = m_x1;
      m_x1 = sig_s;
      e_valid = 0;
      if (m_arm < 0) begin
         if (en_s) m_arm = c;
      end else if (c == m_arm + G + 2) begin
         model_publish();
         m_arm = en_s ? c : -1;
      end else if (!en_s) begin
         m_arm = -1; m_streak = 0; e_good = 0;
      end
   endtask

   initial begin : compare
      model_reset();
      forever begin
         @(negedge clk);
         if (!rstn) begin
            model_reset();
            chk("rst_cnt", 64'(cnt), 0);
            chk("rst_valid", 64'(valid), 0);
            chk("rst_good", 64'(good), 0);
         end else begin
            chk("cnt", 64'(cnt), 64'(e_cnt));
            chk("valid", 64'(valid), 64'(e_valid));
            chk("inrange", 64'(inr), 64'(e_inr));
            chk("loss", 64'(loss), 64'(e_loss));
            chk("good", 64'(good), 64'(e_good));
            model_step(cyc + 1, en, sig);
         end
      end
   end

   // Saturation: period-2 input gives 50 rises, clipped to 31 in a 5-bit counter.
   initial begin : sat_check
      bit seen;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (v31) begin
            seen = 1;
            chk("sat31_cnt", 64'(cnt31), 31);
            chk("sat31_inrange", 64'(i31), 1);
            chk("sat30_valid", 64'(v30), 1);
            chk("sat30_cnt", 64'(cnt30), 31);
            chk("sat30_inrange", 64'(i30), 0);
         end
      end
      if (!seen) chk("sat_valid_timeout", 0, 1);
   end

   // ---------------- stimulus ----------------
   task automatic set_clk(input int p, input int h);
      per = p; hi = h; ph = 0; noise = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      last_good = cur_good;
      cur_good  = good;
      sig_sat   = ~sig_sat;
      if (noise) begin
         sig = 1'($urandom_range(0, 1));
      end else begin
         ph  = (ph + 1) % per;
         sig = (ph < hi);
      end
   endtask

   task automatic wait_valid(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (valid) ok = 1;
      end
      if (!ok) chk({nm, "_timeout"}, 0, 1);
   endtask

   initial begin : stim
      int v1, v2, rel, seen, len, drop, mode, p;
      set_clk(5, 2);
      repeat (5) tick();
      rstn = 1'b1;
      en   = 1'b1;
      rel  = cyc;

      // Period 5: exactly 20 rises per 100-cycle window
      wait_valid("w1");
      v1 = cyc;
      chk("first_valid_latency", 64'(v1 - rel), 103);
      chk("w1_cnt", 64'(cnt), 20);
      chk("w1_inrange", 64'(inr), 1);
      chk("w1_good", 64'(good), 0);
      chk("model_pin_cnt", 64'(e_cnt), 20);
      wait_valid("w2");
      v2 = cyc;
      chk("valid_spacing", 64'(v2 - v1), 102);
      chk("w2_good", 64'(good), 0);
      wait_valid("w3");
      chk("w3_good", 64'(good), 1);
      chk("model_pin_good", 64'(e_good), 1);

      // Period 4: first window already >22 rises, good drops with valid
      set_clk(4, 2);
      wait_valid("p4a");
      chk("p4a_inrange", 64'(inr), 0);
      chk("p4a_good", 64'(good), 0);
      chk("p4a_good_before", 64'(last_good), 1);
      wait_valid("p4b");
      chk("p4b_cnt", 64'(cnt), 25);

      // Pin held low
      set_clk(4, 0);
      wait_valid("lo_a");
      wait_valid("lo_b");
      chk("loss_cnt", 64'(cnt), 0);
      chk("loss_flag", 64'(loss), 1);
      chk("loss_inrange", 64'(inr), 0);
      chk("model_pin_loss", 64'(e_loss), 1);

      // Abort mid-window after reaching good
      set_clk(5, 2);
      repeat (4) wait_valid("ab");
      chk("pre_abort_good", 64'(good), 1);
      repeat (50) tick();
      en   = 1'b0;
      seen = 0;
      repeat (20) begin
         tick();
         if (valid) seen++;
      end
      chk("abort_no_valid", 64'(seen), 0);
      chk("abort_cnt_held", 64'(cnt), 20);
      chk("abort_good", 64'(good), 0);
      en  = 1'b1;
      rel = cyc;
      wait_valid("reen");
      // Arms on the next edge, publishes 102 cycles after arming.
      chk("reenable_latency", 64'(cyc - rel), 103);

      // Asynchronous reset mid-window
      repeat (40) tick();
      #1 rstn = 1'b0;
      #1;
      chk("async_cnt", 64'(cnt), 0);
      chk("async_inrange", 64'(inr), 0);
      chk("async_good", 64'(good), 0);
      repeat (3) tick();
      rstn = 1'b1;
      rel  = cyc;
      wait_valid("post_rst");
      chk("post_reset_latency", 64'(cyc - rel), 103);
      chk("post_reset_cnt", 64'(cnt), 20);

      // Randomized segments, checked by the model every cycle
      for (int s = 0; s < 30; s++) begin
         len  = $urandom_range(80, 220);
         drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 6) : -1;
         mode = $urandom_range(0, 2);
         if (mode == 0) begin
            p = $urandom_range(3, 9);
            set_clk(p, $urandom_range(1, p - 1));
         end else if (mode == 1) begin
            set_clk(5, 2);
            noise = 1;
         end else begin
            set_clk(5, $urandom_range(1, 4));
         end
         for (int i = 0; i < len; i++) begin
            tick();
            en = !(drop >= 0 && i >= drop && i < drop + 5);
         end
      end

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
